// File: rtl/devil_snoop_if.sv
// Snoop-side bundle: AC request strobe plus the CR and CD response channels.
// No latency of its own; CR/CD use valid/ready, and the AC strobe is a one-cycle pulse.
// The engine side uses the slave modport; the snoop FSM or bench side uses the master modport.
interface devil_snoop_if #(
    parameter int ADDR_W = 44,
    parameter int DATA_W = 128
);
    logic              i_snoop_req;
    logic [ADDR_W-1:0] i_acaddr;
    logic [3:0]        i_acsnoop;
    logic              o_crvalid;
    logic              i_crready;
    logic [4:0]        o_crresp;
    logic              o_cdvalid;
    logic              i_cdready;
    logic [DATA_W-1:0] o_cddata;
    logic              o_cdlast;

    modport slave (
        input  i_snoop_req, i_acaddr, i_acsnoop, i_crready, i_cdready,
        output o_crvalid, o_crresp, o_cdvalid, o_cddata, o_cdlast
    );

    modport master (
        output i_snoop_req, i_acaddr, i_acsnoop, i_crready, i_cdready,
        input  o_crvalid, o_crresp, o_cdvalid, o_cddata, o_cdlast
    );
endinterface

// File: rtl/devil_snoop_engine.sv
// Takes over ACE snoops hitting configured address windows; forges delayed CR and optional CD data.
// Latency req->crvalid is 2 cycles plus the programmed delay in modes 1/2.
// CR/CD outputs hold steady until ready; requests arriving while busy are dropped and flagged.
module devil_snoop_engine #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_ACE_DATA_WIDTH   = 128,
    parameter int C_ACE_ADDR_WIDTH   = 44,
    parameter int N_REGIONS          = 2,
    parameter int CD_BEATS           = 4
) (
    input  logic                                  ace_aclk,
    input  logic                                  ace_aresetn,
    devil_snoop_if.slave                          snp,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         i_control_reg,
    input  logic [31:0]                           i_delay_reg,
    input  logic [4:0]                            i_crresp_reg,
    input  logic [31:0]                           i_pattern_reg,
    input  logic [N_REGIONS*C_ACE_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [N_REGIONS*C_ACE_ADDR_WIDTH-1:0] i_addr_size,
    input  logic                                  i_status_clr,
    output logic                                  o_takeover,
    output logic                                  o_bypass,
    output logic                                  o_busy,
    output logic [2:0]                            o_state,
    output logic [15:0]                           o_hit_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         o_status
);
    localparam int AW = C_ACE_ADDR_WIDTH;
    localparam int DW = C_ACE_DATA_WIDTH;
    localparam int BW = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam int CW = 9 + N_REGIONS;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MATCH = 3'd1,
        ST_DELAY = 3'd2,
        ST_RESP  = 3'd3,
        ST_DATA  = 3'd4,
        ST_END   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [3:0]      snoop_q;
    logic [CW-1:0]   ctrl_q;
    logic [31:0]     delay_q;
    logic [4:0]      crresp_q;
    logic [31:0]     pattern_q;
    logic [31:0]     cnt_q;
    logic [BW-1:0]   beat_q;
    logic [15:0]     hit_count_q;
    logic            oneshot_q, rvld_q, drop_q;
    logic [2:0]      region_q;

    logic [N_REGIONS-1:0] in_win;
    logic            win_any;
    logic [2:0]      win_idx;
    logic [1:0]      mode;
    logic            opc_ok, hit, delayed, forge, last_beat;
    logic            take, byp, cr_vld, cd_vld;
    logic            unused_ctrl;

    assign unused_ctrl = ^i_control_reg[C_S_AXI_DATA_WIDTH-1:CW];

    // One extra MSB keeps base+size from wrapping at the top of the address space.
    for (genvar g = 0; g < N_REGIONS; g++) begin : g_win
        logic [AW:0] lo, hi;
        assign lo        = {1'b0, i_base_addr[g*AW +: AW]};
        assign hi        = lo + {1'b0, i_addr_size[g*AW +: AW]};
        assign in_win[g] = ctrl_q[9+g] && ({1'b0, addr_q} >= lo) && ({1'b0, addr_q} < hi);
    end

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (in_win[i]) begin
                win_any = 1'b1;
                win_idx = 3'(i);
            end
        end
    end

    assign mode      = ctrl_q[2:1];
    assign opc_ok    = ctrl_q[4] | (snoop_q == ctrl_q[8:5]);
    assign hit       = ctrl_q[0] & opc_ok & win_any & ~((mode == 2'd1) & oneshot_q);
    assign delayed   = ((mode == 2'd1) || (mode == 2'd2)) && (delay_q != 32'd0);
    assign forge     = ctrl_q[3] & crresp_q[0];
    assign last_beat = (beat_q == BW'(CD_BEATS - 1));

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        byp     = 1'b0;
        cr_vld  = 1'b0;
        cd_vld  = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (snp.i_snoop_req) state_d = ST_MATCH;
            ST_MATCH: begin
                take = hit;
                byp  = ~hit;
                if (!hit)        state_d = ST_IDLE;
                else if (delayed) state_d = ST_DELAY;
                else             state_d = ST_RESP;
            end
            ST_DELAY: begin
                take = 1'b1;
                if (cnt_q == 32'd1) state_d = ST_RESP;
            end
            ST_RESP: begin
                take   = 1'b1;
                cr_vld = 1'b1;
                if (snp.i_crready) state_d = forge ? ST_DATA : ST_END;
            end
            ST_DATA: begin
                take   = 1'b1;
                cd_vld = 1'b1;
                if (snp.i_cdready && last_beat) state_d = ST_END;
            end
            ST_END:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ace_aclk or negedge ace_aresetn) begin
        if (!ace_aresetn) begin
            addr_q      <= '0;
            snoop_q     <= '0;
            ctrl_q      <= '0;
            delay_q     <= '0;
            crresp_q    <= '0;
            pattern_q   <= '0;
            cnt_q       <= '0;
            beat_q      <= '0;
            hit_count_q <= '0;
            oneshot_q   <= 1'b0;
            rvld_q      <= 1'b0;
            region_q    <= '0;
            drop_q      <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && snp.i_snoop_req) begin
                addr_q    <= snp.i_acaddr;
                snoop_q   <= snp.i_acsnoop;
                ctrl_q    <= i_control_reg[CW-1:0];
                delay_q   <= i_delay_reg;
                crresp_q  <= i_crresp_reg;
                pattern_q <= i_pattern_reg;
            end
            if (state_q == ST_MATCH)      cnt_q <= delay_q;
            else if (state_q == ST_DELAY) cnt_q <= cnt_q - 32'd1;
            if (state_q == ST_RESP)                          beat_q <= '0;
            else if (state_q == ST_DATA && snp.i_cdready)    beat_q <= beat_q + BW'(1);
            // A clear arriving with a hit or a drop takes priority.
            if (i_status_clr) begin
                hit_count_q <= '0;
                oneshot_q   <= 1'b0;
                rvld_q      <= 1'b0;
                region_q    <= '0;
                drop_q      <= 1'b0;
            end else begin
                if (state_q == ST_MATCH && hit) begin
                    if (hit_count_q != 16'hFFFF) hit_count_q <= hit_count_q + 16'd1;
                    rvld_q   <= 1'b1;
                    region_q <= win_idx;
                    if (mode == 2'd1) oneshot_q <= 1'b1;
                end
                if (state_q != ST_IDLE && snp.i_snoop_req) drop_q <= 1'b1;
            end
        end
    end

    assign o_takeover  = take;
    assign o_bypass    = byp;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_state     = state_q;
    assign o_hit_count = hit_count_q;
    assign o_status    = {{(C_S_AXI_DATA_WIDTH-6){1'b0}}, drop_q, region_q, rvld_q, oneshot_q};

    assign snp.o_crvalid = cr_vld;
    assign snp.o_crresp  = cr_vld ? crresp_q : 5'd0;
    assign snp.o_cdvalid = cd_vld;
    assign snp.o_cdlast  = cd_vld & last_beat;
    assign snp.o_cddata  = cd_vld ? ({(DW/32){pattern_q}} ^ {{(DW-8){1'b0}}, 8'(beat_q)}) : '0;
endmodule
